// File: rtl/i2c_frame_parser.sv
// i2c_frame_parser: turns a stream of decoded I2C bus symbols (START, bit 1,
// bit 0, STOP) into framed bytes. Address and data bytes are reported with
// their acknowledge bit, a per-frame data byte index and error pulses for
// malformed traffic.
//
// Handshake: a symbol is consumed on every rising clock edge where sym_valid
// is 1; sym_data is ignored otherwise. There is no backpressure. Every output
// is registered, so each pulse (byte_valid, frame_start, frame_stop, err)
// appears exactly one cycle after the symbol that caused it. Each pulse lasts
// one cycle, and there is no ready signal.
//
// The FSM state is held in the named enum register 'state' so that checkers
// can bind to it directly.
module i2c_frame_parser #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [2:0] sym_data,
  input  logic       sym_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_is_addr,
  output logic       byte_ack,
  output logic [7:0] byte_index,
  output logic       rw,
  output logic       addr_match,
  output logic       busy,
  output logic       frame_start,
  output logic       frame_stop,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [2:0] SYM_START = 3'd1;
  localparam logic [2:0] SYM_BIT1  = 3'd2;
  localparam logic [2:0] SYM_BIT0  = 3'd3;
  localparam logic [2:0] SYM_STOP  = 3'd4;

  localparam logic [1:0] ERR_TRUNC   = 2'd1;
  localparam logic [1:0] ERR_OUTSIDE = 2'd2;
  localparam logic [1:0] ERR_BADSYM  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    DATA,
    ACK_D,
    HOLD
  } state_t;

  state_t     state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;

  logic bit_val;
  logic truncated;

  // Value carried by a bit symbol, and whether a START or STOP now would cut a byte short.
  always_comb begin
    bit_val   = (sym_data == SYM_BIT1);
    truncated = (((state == ADDR) || (state == DATA)) && (bit_cnt != 3'd0)) ||
                (state == ACK_A) || (state == ACK_D);
  end

  // Symbol-driven frame FSM with registered outputs and pulses.
  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= IDLE;
      shift_reg    <= 8'd0;
      bit_cnt      <= 3'd0;
      byte_data    <= 8'd0;
      byte_valid   <= 1'b0;
      byte_is_addr <= 1'b0;
      byte_ack     <= 1'b0;
      byte_index   <= 8'd0;
      rw           <= 1'b0;
      addr_match   <= 1'b0;
      busy         <= 1'b0;
      frame_start  <= 1'b0;
      frame_stop   <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_stop  <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
      if (sym_valid) begin
        case (sym_data)
          SYM_START: begin
            if (truncated) begin
              err      <= 1'b1;
              err_code <= ERR_TRUNC;
            end
            state       <= ADDR;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            byte_index  <= 8'd0;
            busy        <= 1'b1;
            frame_start <= 1'b1;
          end
          SYM_STOP: begin
            // A STOP with no open frame is silently dropped.
            if (state != IDLE) begin
              if (truncated) begin
                err      <= 1'b1;
                err_code <= ERR_TRUNC;
              end
              state      <= IDLE;
              bit_cnt    <= 3'd0;
              shift_reg  <= 8'd0;
              busy       <= 1'b0;
              addr_match <= 1'b0;
              rw         <= 1'b0;
              frame_stop <= 1'b1;
            end
          end
          SYM_BIT1, SYM_BIT0: begin
            case (state)
              IDLE: begin
                err      <= 1'b1;
                err_code <= ERR_OUTSIDE;
              end
              ADDR, DATA: begin
                shift_reg <= {shift_reg[6:0], bit_val};
                if (bit_cnt == 3'd7) begin
                  bit_cnt <= 3'd0;
                  state   <= (state == ADDR) ? ACK_A : ACK_D;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
              ACK_A: begin
                byte_valid   <= 1'b1;
                byte_data    <= shift_reg;
                byte_ack     <= ~bit_val;
                byte_is_addr <= 1'b1;
                rw           <= shift_reg[0];
                addr_match   <= (shift_reg[7:1] == DEV_ADDR);
                state        <= bit_val ? HOLD : DATA;
              end
              ACK_D: begin
                byte_valid   <= 1'b1;
                byte_data    <= shift_reg;
                byte_ack     <= ~bit_val;
                byte_is_addr <= 1'b0;
                if (byte_index != 8'hFF) begin
                  byte_index <= byte_index + 8'd1;
                end
                state <= bit_val ? HOLD : DATA;
              end
              default: begin
                // HOLD: bits after a NACK are not ours; wait for START/STOP.
              end
            endcase
          end
          default: begin
            err      <= 1'b1;
            err_code <= ERR_BADSYM;
          end
        endcase
      end
    end
  end

endmodule
